// File: rtl/audiosystem_timer_pkg.sv
// Shared definitions for the audio-system interval-timer controller:
// timer register map, control-word bit positions and controller states.
package audiosystem_timer_pkg;

    localparam logic [2:0] TMR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_PERIOD_H = 3'd3;
    localparam logic [2:0] TMR_SNAP_L   = 3'd4;
    localparam logic [2:0] TMR_SNAP_H   = 3'd5;

    localparam int unsigned ITO   = 0;
    localparam int unsigned CONT  = 1;
    localparam int unsigned START = 2;
    localparam int unsigned STOP  = 3;

    localparam logic [15:0] STOP_WORD = 16'(1) << STOP;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_PL     = 4'd1,
        WR_PH     = 4'd2,
        WR_CTRL   = 4'd3,
        RUN       = 4'd4,
        CLR_ST    = 4'd5,
        SNAP_WR   = 4'd6,
        SNAP_RD_L = 4'd7,
        SNAP_RD_H = 4'd8,
        SNAP_CAP  = 4'd9,
        STOP_WR   = 4'd10,
        STOP_CLR  = 4'd11
    } state_t;

    // Run word: interrupt enable + start, continuous bit optional.
    function automatic logic [15:0] ctrl_word(input logic cont);
        logic [15:0] w;
        w        = '0;
        w[ITO]   = 1'b1;
        w[CONT]  = cont;
        w[START] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/audiosystem_timer_ctrl.sv
// Avalon-MM master that programs the interval timer, services its timeouts
// as audio ticks and takes on-demand counter snapshots.
module audiosystem_timer_ctrl
    import audiosystem_timer_pkg::*;
#(
    parameter int unsigned CONTINUOUS = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      cfg_period,
    input  logic             start,
    input  logic             stop,
    input  logic             snap_req,
    output logic             busy,
    output logic             running,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic [31:0]      snap_value,
    output logic             snap_valid,
    output logic [2:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic             avm_read_n,
    output logic [15:0]      avm_writedata,
    input  logic [15:0]      avm_readdata,
    input  logic             timer_irq
);

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_period_h;
    logic             r_stop_pend;
    logic             r_snap_pend;
    logic             r_run_ctx;
    logic             r_tick;
    logic             r_snap_valid;
    logic [CNT_W-1:0] r_tick_count;
    logic [31:0]      r_snap_value;
    logic [2:0]       r_addr;
    logic             r_cs;
    logic             r_write_n;
    logic             r_read_n;
    logic [15:0]      r_wdata;

    logic w_start_ok;
    logic w_stop_any;
    logic w_snap_any;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == RUN));
    assign w_stop_any = r_stop_pend || stop;
    assign w_snap_any = r_snap_pend || snap_req;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start)           w_next = WR_PL;
                else if (w_snap_any) w_next = SNAP_WR;
            end
            WR_PL:     w_next = WR_PH;
            WR_PH:     w_next = WR_CTRL;
            WR_CTRL:   w_next = RUN;
            RUN: begin
                if (start)           w_next = WR_PL;
                else if (timer_irq)  w_next = CLR_ST;
                else if (w_stop_any) w_next = STOP_WR;
                else if (w_snap_any) w_next = SNAP_WR;
            end
            CLR_ST:    w_next = (CONTINUOUS != 0) ? RUN : IDLE;
            SNAP_WR:   w_next = SNAP_RD_L;
            SNAP_RD_L: w_next = SNAP_RD_H;
            SNAP_RD_H: w_next = SNAP_CAP;
            SNAP_CAP:  w_next = r_run_ctx ? RUN : IDLE;
            STOP_WR:   w_next = STOP_CLR;
            STOP_CLR:  w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so each access lines up
    // with the cycle spent in the corresponding state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_period_h   <= '0;
            r_stop_pend  <= 1'b0;
            r_snap_pend  <= 1'b0;
            r_run_ctx    <= 1'b0;
            r_tick       <= 1'b0;
            r_snap_valid <= 1'b0;
            r_tick_count <= '0;
            r_snap_value <= '0;
            r_addr       <= '0;
            r_cs         <= 1'b0;
            r_write_n    <= 1'b1;
            r_read_n     <= 1'b1;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_next;
            r_stop_pend  <= (r_state == IDLE || w_start_ok || w_next == STOP_WR) ? 1'b0 : w_stop_any;
            r_snap_pend  <= (w_next == SNAP_WR) ? 1'b0 : w_snap_any;
            r_run_ctx    <= (w_next != IDLE) && ((r_state == RUN) || r_run_ctx);
            r_tick       <= (w_next == CLR_ST);
            r_snap_valid <= (r_state == SNAP_CAP);

            if (w_start_ok) begin
                r_period_h <= cfg_period[31:16];
            end

            if (w_start_ok) begin
                r_tick_count <= '0;
            end else if (w_next == CLR_ST) begin
                r_tick_count <= r_tick_count + CNT_W'(1);
            end

            if (r_state == SNAP_RD_H) begin
                r_snap_value[15:0] <= avm_readdata;
            end
            if (r_state == SNAP_CAP) begin
                r_snap_value[31:16] <= avm_readdata;
            end

            r_cs      <= 1'b0;
            r_write_n <= 1'b1;
            r_read_n  <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            case (w_next)
                WR_PL: begin
                    r_cs <= 1'b1; r_write_n <= 1'b0;
                    r_addr <= TMR_PERIOD_L; r_wdata <= cfg_period[15:0];
                end
                WR_PH: begin
                    r_cs <= 1'b1; r_write_n <= 1'b0;
                    r_addr <= TMR_PERIOD_H; r_wdata <= r_period_h;
                end
                WR_CTRL: begin
                    r_cs <= 1'b1; r_write_n <= 1'b0;
                    r_addr <= TMR_CONTROL; r_wdata <= ctrl_word(CONTINUOUS != 0);
                end
                CLR_ST, STOP_CLR: begin
                    r_cs <= 1'b1; r_write_n <= 1'b0;
                    r_addr <= TMR_STATUS;
                end
                SNAP_WR: begin
                    r_cs <= 1'b1; r_write_n <= 1'b0;
                    r_addr <= TMR_SNAP_L;
                end
                SNAP_RD_L: begin
                    r_cs <= 1'b1; r_read_n <= 1'b0;
                    r_addr <= TMR_SNAP_L;
                end
                SNAP_RD_H: begin
                    r_cs <= 1'b1; r_read_n <= 1'b0;
                    r_addr <= TMR_SNAP_H;
                end
                STOP_WR: begin
                    r_cs <= 1'b1; r_write_n <= 1'b0;
                    r_addr <= TMR_CONTROL; r_wdata <= STOP_WORD;
                end
                default: ;
            endcase
        end
    end

    assign busy           = (r_state != IDLE) && (r_state != RUN);
    assign running        = (r_state == RUN) || (r_run_ctx && (r_state != IDLE));
    assign tick           = r_tick;
    assign tick_count     = r_tick_count;
    assign snap_value     = r_snap_value;
    assign snap_valid     = r_snap_valid;
    assign avm_address    = r_addr;
    assign avm_chipselect = r_cs;
    assign avm_write_n    = r_write_n;
    assign avm_read_n     = r_read_n;
    assign avm_writedata  = r_wdata;

endmodule

// File: tb/tb_audiosystem_timer_ctrl.sv
// Bench for audiosystem_timer_ctrl: a continuous and a one-shot instance,
// each attached to a behavioural timer slave, with a bus access log.
module tb_audiosystem_timer_ctrl;

    typedef struct {
        int         cyc;
        bit         wr;
        logic [2:0] addr;
        logic [15:0] data;
    } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        start_s   [2];
    logic        stop_s    [2];
    logic        snap_s    [2];
    logic [31:0] cfg       [2];
    logic        busy      [2];
    logic        running   [2];
    logic        tick      [2];
    logic [15:0] tcount    [2];
    logic [31:0] snap_val  [2];
    logic        snap_vld  [2];
    logic [2:0]  addr      [2];
    logic        cs        [2];
    logic        wn        [2];
    logic        rn        [2];
    logic [15:0] wd        [2];
    logic [15:0] rd        [2];
    logic        irq       [2];
    logic        irq_raise [2];
    logic [31:0] model_cnt [2];
    logic [31:0] snap_reg  [2];

    int   cyc = 0;
    acc_t acc_log [2][$];
    int   tick_hi [2] = '{0, 0};
    int   sv_hi   [2] = '{0, 0};
    int   sv_cyc  [2] = '{0, 0};
    logic [31:0] sv_val [2] = '{32'h0, 32'h0};

    acc_t exp_q [$];
    int   lb [2] = '{0, 0};
    int   n_checks = 0;
    int   n_errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        audiosystem_timer_ctrl #(
            .CONTINUOUS((g == 0) ? 1 : 0),
            .CNT_W(16)
        ) u_dut (
            .clk(clk),
            .reset(rst[g]),
            .cfg_period(cfg[g]),
            .start(start_s[g]),
            .stop(stop_s[g]),
            .snap_req(snap_s[g]),
            .busy(busy[g]),
            .running(running[g]),
            .tick(tick[g]),
            .tick_count(tcount[g]),
            .snap_value(snap_val[g]),
            .snap_valid(snap_vld[g]),
            .avm_address(addr[g]),
            .avm_chipselect(cs[g]),
            .avm_write_n(wn[g]),
            .avm_read_n(rn[g]),
            .avm_writedata(wd[g]),
            .avm_readdata(rd[g]),
            .timer_irq(irq[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Timer slave: irq held until status written, snapshot on snap_l write,
    // registered read data one cycle after the address.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst[g]) begin
                irq[g]      <= 1'b0;
                snap_reg[g] <= 32'h0;
            end else begin
                if (irq_raise[g]) irq[g] <= 1'b1;
                else if (cs[g] && !wn[g] && addr[g] == 3'd0) irq[g] <= 1'b0;
                if (cs[g] && !wn[g] && addr[g] == 3'd4) snap_reg[g] <= model_cnt[g];
            end
            rd[g] <= (addr[g] == 3'd4) ? snap_reg[g][15:0] :
                     (addr[g] == 3'd5) ? snap_reg[g][31:16] : 16'h0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (cs[g] === 1'b1 && (wn[g] === 1'b0 || rn[g] === 1'b0)) begin
                acc_t e;
                e.cyc = cyc; e.wr = (wn[g] === 1'b0); e.addr = addr[g]; e.data = wd[g];
                acc_log[g].push_back(e);
            end
            if (tick[g] === 1'b1) tick_hi[g]++;
            if (snap_vld[g] === 1'b1) begin
                sv_hi[g]++;
                sv_cyc[g] = cyc;
                sv_val[g] = snap_val[g];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_acc(input bit wr, input logic [2:0] a, input logic [15:0] d);
        acc_t e;
        e.cyc = 0; e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_start(input int g, input logic [31:0] p);
        push_acc(1'b1, 3'd2, p[15:0]);
        push_acc(1'b1, 3'd3, p[31:16]);
        push_acc(1'b1, 3'd1, (g == 0) ? 16'h0007 : 16'h0005);
    endfunction

    function automatic void exp_snap();
        push_acc(1'b1, 3'd4, 16'h0);
        push_acc(1'b0, 3'd4, 16'h0);
        push_acc(1'b0, 3'd5, 16'h0);
    endfunction

    task automatic check_log(input int g, input string tag, input bit consec);
        int n;
        int got;
        got = acc_log[g].size() - lb[g];
        check({tag, "_count"}, 32'(got), 32'(exp_q.size()));
        n = (got < exp_q.size()) ? got : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_wr%0d", tag, i), 32'(acc_log[g][lb[g]+i].wr), 32'(exp_q[i].wr));
            check($sformatf("%s_addr%0d", tag, i), 32'(acc_log[g][lb[g]+i].addr), 32'(exp_q[i].addr));
            if (exp_q[i].wr)
                check($sformatf("%s_data%0d", tag, i), 32'(acc_log[g][lb[g]+i].data), 32'(exp_q[i].data));
            if (consec && i > 0)
                check($sformatf("%s_cyc%0d", tag, i),
                      32'(acc_log[g][lb[g]+i].cyc - acc_log[g][lb[g]].cyc), 32'(i));
        end
        lb[g] = acc_log[g].size();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input int g, input string tag);
        check({tag, "_cs"}, 32'(cs[g]), 32'h0);
        check({tag, "_write_n"}, 32'(wn[g]), 32'h1);
        check({tag, "_read_n"}, 32'(rn[g]), 32'h1);
        check({tag, "_addr"}, 32'(addr[g]), 32'h0);
        check({tag, "_wdata"}, 32'(wd[g]), 32'h0);
        check({tag, "_busy"}, 32'(busy[g]), 32'h0);
        check({tag, "_running"}, 32'(running[g]), 32'h0);
        check({tag, "_tick"}, 32'(tick[g]), 32'h0);
        check({tag, "_tick_count"}, 32'(tcount[g]), 32'h0);
        check({tag, "_snap_value"}, snap_val[g], 32'h0);
        check({tag, "_snap_valid"}, 32'(snap_vld[g]), 32'h0);
    endtask

    task automatic pulse_start(input int g);
        @(negedge clk) start_s[g] = 1'b1;
        @(negedge clk) start_s[g] = 1'b0;
    endtask

    task automatic pulse_stop(input int g);
        @(negedge clk) stop_s[g] = 1'b1;
        @(negedge clk) stop_s[g] = 1'b0;
    endtask

    task automatic pulse_snap(input int g);
        @(negedge clk) snap_s[g] = 1'b1;
        @(negedge clk) snap_s[g] = 1'b0;
    endtask

    task automatic raise_irq(input int g);
        @(negedge clk) irq_raise[g] = 1'b1;
        @(negedge clk) irq_raise[g] = 1'b0;
    endtask

    initial begin
        int t0;
        int s0;
        int w4_cyc;
        int exp_tc;
        logic [31:0] p;

        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; start_s[g] = 1'b0; stop_s[g] = 1'b0; snap_s[g] = 1'b0;
            cfg[g] = 32'h0; irq_raise[g] = 1'b0; model_cnt[g] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "rst0");
        check_reset_outputs(1, "rst1");
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);

        // Program and start the continuous instance.
        cfg[0] = 32'h02FAF07F;
        pulse_start(0);
        check("start_busy0", 32'(busy[0]), 32'h1);
        check("start_run0", 32'(running[0]), 32'h0);
        @(negedge clk) check("start_busy1", 32'(busy[0]), 32'h1);
        @(negedge clk) check("start_busy2", 32'(busy[0]), 32'h1);
        @(negedge clk) check("start_busy3", 32'(busy[0]), 32'h0);
        check("start_running", 32'(running[0]), 32'h1);
        repeat (2) @(negedge clk);
        exp_start(0, 32'h02FAF07F);
        check_log(0, "start", 1'b1);

        // Three timeouts, three ticks.
        t0 = tick_hi[0];
        exp_tc = 0;
        for (int k = 0; k < 3; k++) begin
            raise_irq(0);
            repeat (4) @(negedge clk);
            push_acc(1'b1, 3'd0, 16'h0);
            exp_tc++;
        end
        check("irq_ticks", 32'(tick_hi[0] - t0), 32'(exp_tc));
        check("irq_tick_count", 32'(tcount[0]), 32'(exp_tc));
        check("irq_cleared", 32'(irq[0]), 32'h0);
        check_log(0, "irq", 1'b0);

        // Snapshot with a fixed then random counter values.
        for (int k = 0; k < 4; k++) begin
            model_cnt[0] = (k == 0) ? 32'h00012345 : $urandom;
            s0 = sv_hi[0];
            pulse_snap(0);
            repeat (6) @(negedge clk);
            w4_cyc = (acc_log[0].size() > lb[0]) ? acc_log[0][lb[0]].cyc : -100;
            check($sformatf("snap_valid_n%0d", k), 32'(sv_hi[0] - s0), 32'h1);
            check($sformatf("snap_value%0d", k), sv_val[0], model_cnt[0]);
            check($sformatf("snap_latency%0d", k), 32'(sv_cyc[0] - w4_cyc), 32'd4);
            check($sformatf("snap_running%0d", k), 32'(running[0]), 32'h1);
            exp_snap();
            check_log(0, $sformatf("snap%0d", k), 1'b1);
        end

        // irq and snap_req together: tick first, snapshot after.
        model_cnt[0] = $urandom;
        t0 = tick_hi[0];
        s0 = sv_hi[0];
        @(negedge clk) irq_raise[0] = 1'b1;
        @(negedge clk) begin irq_raise[0] = 1'b0; snap_s[0] = 1'b1; end
        @(negedge clk) snap_s[0] = 1'b0;
        repeat (8) @(negedge clk);
        exp_tc++;
        check("both_ticks", 32'(tick_hi[0] - t0), 32'h1);
        check("both_snaps", 32'(sv_hi[0] - s0), 32'h1);
        check("both_value", sv_val[0], model_cnt[0]);
        check("both_tick_count", 32'(tcount[0]), 32'(exp_tc));
        push_acc(1'b1, 3'd0, 16'h0);
        exp_snap();
        check_log(0, "both", 1'b0);

        // Reprogram while running clears the tick count.
        p = $urandom;
        cfg[0] = p;
        pulse_start(0);
        repeat (5) @(negedge clk);
        check("reprog_tick_count", 32'(tcount[0]), 32'h0);
        check("reprog_running", 32'(running[0]), 32'h1);
        exp_start(0, p);
        check_log(0, "reprog", 1'b1);

        // Stop, then an irq must go unserviced.
        pulse_stop(0);
        repeat (4) @(negedge clk);
        check("stop_running", 32'(running[0]), 32'h0);
        check("stop_busy", 32'(busy[0]), 32'h0);
        push_acc(1'b1, 3'd1, 16'h0008);
        push_acc(1'b1, 3'd0, 16'h0000);
        check_log(0, "stop", 1'b1);
        t0 = tick_hi[0];
        raise_irq(0);
        repeat (5) @(negedge clk);
        check("stopped_ticks", 32'(tick_hi[0] - t0), 32'h0);
        check_log(0, "stopped", 1'b0);

        // One-shot instance: a single tick, then back to idle.
        cfg[1] = 32'h00000010;
        pulse_start(1);
        repeat (4) @(negedge clk);
        check("os_running", 32'(running[1]), 32'h1);
        exp_start(1, 32'h00000010);
        check_log(1, "os_start", 1'b1);
        t0 = tick_hi[1];
        raise_irq(1);
        repeat (4) @(negedge clk);
        check("os_ticks", 32'(tick_hi[1] - t0), 32'h1);
        check("os_tick_count", 32'(tcount[1]), 32'h1);
        check("os_running_after", 32'(running[1]), 32'h0);
        check("os_busy_after", 32'(busy[1]), 32'h0);
        push_acc(1'b1, 3'd0, 16'h0);
        check_log(1, "os_irq", 1'b0);

        // Reset while writing period_h: bus released, nothing resumes.
        p = $urandom;
        cfg[1] = p;
        pulse_start(1);
        @(negedge clk) rst[1] = 1'b1;
        @(negedge clk);
        check_reset_outputs(1, "midrst");
        rst[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_idle_busy", 32'(busy[1]), 32'h0);
        push_acc(1'b1, 3'd2, p[15:0]);
        push_acc(1'b1, 3'd3, p[31:16]);
        check_log(1, "midrst", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
